// File: rtl/system_0_timer_multi.sv
// -----------------------------------------------------------------------------
// system_0_timer_multi
//   Bank of NUM_CHANNELS independent down-counting timers behind one Avalon-MM
//   slave. Each channel has a prescaler, a reloadable counter, a sticky
//   timeout flag and an interrupt enable. The channel interrupts are ORed
//   onto irq.
//
// Ports
//   clk        : single clock
//   reset_n    : asynchronous active-low reset
//   address    : {channel, register}; the low 3 bits select the register
//   chipselect : slave select; a write is chipselect && !write_n
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : registered read data for the address sampled last cycle
//   irq        : OR over channels of (TO && ITO)
//
// Per-channel register map
//   0 STATUS   b0 TO, b1 RUN (any write clears TO)
//   1 CONTROL  b0 ITO, b1 CONT, b2 START, b3 STOP (strobes read back 0)
//   2 PERIOD   3 SNAPSHOT   4 PRESCALE   5 IRQ_VEC (read-only)   6-7 zero
// -----------------------------------------------------------------------------
module system_0_timer_multi #(
   parameter int NUM_CHANNELS   = 4,
   parameter int COUNTER_WIDTH  = 32,
   parameter int PRESCALE_WIDTH = 16,
   parameter int DEFAULT_PERIOD = 49999
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [$clog2(NUM_CHANNELS)+2:0]   address,
   input  logic                              chipselect,
   input  logic                              write_n,
   input  logic [31:0]                       writedata,
   output logic [31:0]                       readdata,
   output logic                              irq
);

   localparam int ADDR_W = $clog2(NUM_CHANNELS) + 3;

   localparam logic [2:0] REG_STATUS   = 3'd0;
   localparam logic [2:0] REG_CONTROL  = 3'd1;
   localparam logic [2:0] REG_PERIOD   = 3'd2;
   localparam logic [2:0] REG_SNAPSHOT = 3'd3;
   localparam logic [2:0] REG_PRESCALE = 3'd4;
   localparam logic [2:0] REG_IRQ_VEC  = 3'd5;

   logic              wr_en;
   logic [ADDR_W-1:0] ch_sel;
   logic [2:0]        reg_sel;

   // Channel number kept at full address width so a single-channel build
   // (no channel bits at all) still decodes cleanly.
   assign wr_en   = chipselect && !write_n;
   assign ch_sel  = address >> 3;
   assign reg_sel = address[2:0];

   logic [NUM_CHANNELS-1:0]   to_v;
   logic [NUM_CHANNELS-1:0]   run_v;
   logic [NUM_CHANNELS-1:0]   ito_v;
   logic [NUM_CHANNELS-1:0]   cont_v;
   logic [NUM_CHANNELS-1:0]   irq_vec;
   logic [COUNTER_WIDTH-1:0]  period_a   [NUM_CHANNELS];
   logic [COUNTER_WIDTH-1:0]  snap_a     [NUM_CHANNELS];
   logic [PRESCALE_WIDTH-1:0] prescale_a [NUM_CHANNELS];

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic [COUNTER_WIDTH-1:0]  counter_r;
      logic [COUNTER_WIDTH-1:0]  period_r;
      logic [COUNTER_WIDTH-1:0]  snap_r;
      logic [PRESCALE_WIDTH-1:0] prescale_r;
      logic [PRESCALE_WIDTH-1:0] pcnt_r;
      logic                      to_r;
      logic                      run_r;
      logic                      ito_r;
      logic                      cont_r;

      logic sel;
      logic wr_status;
      logic wr_ctrl;
      logic wr_period;
      logic wr_snap;
      logic wr_pre;
      logic tick;
      logic timeout;

      assign sel       = wr_en && (ch_sel == ADDR_W'(c));
      assign wr_status = sel && (reg_sel == REG_STATUS);
      assign wr_ctrl   = sel && (reg_sel == REG_CONTROL);
      assign wr_period = sel && (reg_sel == REG_PERIOD);
      assign wr_snap   = sel && (reg_sel == REG_SNAPSHOT);
      assign wr_pre    = sel && (reg_sel == REG_PRESCALE);

      assign tick      = run_r && (pcnt_r == '0);
      // A PERIOD write in the same cycle overrides the expiry entirely.
      assign timeout   = tick && (counter_r == '0) && !wr_period;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            counter_r  <= COUNTER_WIDTH'(DEFAULT_PERIOD);
            period_r   <= COUNTER_WIDTH'(DEFAULT_PERIOD);
            snap_r     <= '0;
            prescale_r <= '0;
            pcnt_r     <= '0;
            to_r       <= 1'b0;
            run_r      <= 1'b0;
            ito_r      <= 1'b0;
            cont_r     <= 1'b0;
         end else begin
            if (wr_pre)
               pcnt_r <= writedata[PRESCALE_WIDTH-1:0];
            else if (wr_period)
               pcnt_r <= prescale_r;
            else if (run_r)
               pcnt_r <= (pcnt_r == '0) ? prescale_r
                                        : pcnt_r - PRESCALE_WIDTH'(1);

            if (wr_period)
               counter_r <= writedata[COUNTER_WIDTH-1:0];
            else if (tick)
               counter_r <= (counter_r == '0) ? period_r
                                              : counter_r - COUNTER_WIDTH'(1);

            if (wr_period) period_r   <= writedata[COUNTER_WIDTH-1:0];
            if (wr_pre)    prescale_r <= writedata[PRESCALE_WIDTH-1:0];
            if (wr_snap)   snap_r     <= counter_r;

            if (wr_ctrl) begin
               ito_r  <= writedata[0];
               cont_r <= writedata[1];
            end

            // START beats STOP; a one-shot expiry only stops the channel
            // when no explicit START/STOP arrives in the same cycle.
            if (wr_period)
               run_r <= 1'b0;
            else if (wr_ctrl && writedata[2])
               run_r <= 1'b1;
            else if (wr_ctrl && writedata[3])
               run_r <= 1'b0;
            else if (timeout && !cont_r)
               run_r <= 1'b0;

            // The expiry event wins over a simultaneous software clear.
            if (timeout)
               to_r <= 1'b1;
            else if (wr_status)
               to_r <= 1'b0;
         end
      end

      assign to_v[c]       = to_r;
      assign run_v[c]      = run_r;
      assign ito_v[c]      = ito_r;
      assign cont_v[c]     = cont_r;
      assign period_a[c]   = period_r;
      assign snap_a[c]     = snap_r;
      assign prescale_a[c] = prescale_r;
   end

   assign irq_vec = to_v & ito_v;
   assign irq     = |irq_vec;

   // Stage p0: read mux, independent of chipselect
   logic [31:0] rdata_p0;

   always_comb begin
      rdata_p0 = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (ch_sel == ADDR_W'(c)) begin
            case (reg_sel)
               REG_STATUS:   rdata_p0 = {30'd0, run_v[c], to_v[c]};
               REG_CONTROL:  rdata_p0 = {30'd0, cont_v[c], ito_v[c]};
               REG_PERIOD:   rdata_p0 = 32'(period_a[c]);
               REG_SNAPSHOT: rdata_p0 = 32'(snap_a[c]);
               REG_PRESCALE: rdata_p0 = 32'(prescale_a[c]);
               REG_IRQ_VEC:  rdata_p0 = 32'(irq_vec);
               default:      rdata_p0 = '0;
            endcase
         end
      end
   end

   // Stage p1: registered read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         readdata <= '0;
      else
         readdata <= rdata_p0;
   end

endmodule

// File: tb/tb_system_0_timer_multi.sv
// -----------------------------------------------------------------------------
// tb_system_0_timer_multi
//   Self-checking bench for system_0_timer_multi (4 channels, 16-bit counters,
//   4-bit prescalers). A behavioural model tracks each channel as "elapsed
//   prescale cycles" plus a counter value and predicts readdata and irq every
//   cycle. Directed scenarios cover the key timing cases; randomized register
//   traffic follows.
// -----------------------------------------------------------------------------
module tb_system_0_timer_multi;

   localparam int NCH  = 4;
   localparam int CW   = 16;
   localparam int PW   = 4;
   localparam int DEFP = 49999;
   localparam logic [31:0] CMASK = 32'h0000_FFFF;
   localparam logic [31:0] PMASK = 32'h0000_000F;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   system_0_timer_multi #(
      .NUM_CHANNELS  (NCH),
      .COUNTER_WIDTH (CW),
      .PRESCALE_WIDTH(PW),
      .DEFAULT_PERIOD(DEFP)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int unsigned m_period [NCH];
   int unsigned m_cnt    [NCH];
   int unsigned m_snap   [NCH];
   int unsigned m_pre    [NCH];
   int unsigned m_pe     [NCH];   // prescale cycles elapsed since last tick/reload
   bit          m_to     [NCH];
   bit          m_run    [NCH];
   bit          m_ito    [NCH];
   bit          m_cont   [NCH];

   task automatic m_reset();
      for (int c = 0; c < NCH; c++) begin
         m_period[c] = DEFP;
         m_cnt[c]    = DEFP;
         m_snap[c]   = 0;
         m_pre[c]    = 0;
         m_pe[c]     = 0;
         m_to[c]     = 1'b0;
         m_run[c]    = 1'b0;
         m_ito[c]    = 1'b0;
         m_cont[c]   = 1'b0;
      end
   endtask

   function automatic logic [31:0] m_vec();
      logic [31:0] v = '0;
      for (int c = 0; c < NCH; c++) v[c] = m_to[c] & m_ito[c];
      return v;
   endfunction

   function automatic logic [31:0] m_read(logic [4:0] a);
      int ch = a[4:3];
      int r  = a[2:0];
      case (r)
         0: return {30'd0, m_run[ch], m_to[ch]};
         1: return {30'd0, m_cont[ch], m_ito[ch]};
         2: return m_period[ch];
         3: return m_snap[ch];
         4: return m_pre[ch];
         5: return m_vec();
         default: return 32'd0;
      endcase
   endfunction

   // One clock edge of the whole timer bank.
   task automatic m_edge(bit wr, logic [4:0] a, logic [31:0] wd);
      int wc = a[4:3];
      int r  = a[2:0];
      for (int c = 0; c < NCH; c++) begin
         bit          tick;
         bit          tmo;
         bit          old_to;
         int unsigned old_cnt;
         old_to  = m_to[c];
         old_cnt = m_cnt[c];
         tick    = m_run[c] && (m_pe[c] == m_pre[c]);
         tmo     = tick && (m_cnt[c] == 0);
         if (m_run[c]) m_pe[c] = tick ? 0 : m_pe[c] + 1;
         if (tmo) begin
            m_cnt[c] = m_period[c];
            m_to[c]  = 1'b1;
            if (!m_cont[c]) m_run[c] = 1'b0;
         end else if (tick) begin
            m_cnt[c] = m_cnt[c] - 1;
         end
         if (wr && wc == c) begin
            case (r)
               0: if (!tmo) m_to[c] = 1'b0;
               1: begin
                  m_ito[c]  = wd[0];
                  m_cont[c] = wd[1];
                  if (wd[2])      m_run[c] = 1'b1;
                  else if (wd[3]) m_run[c] = 1'b0;
               end
               2: begin
                  m_period[c] = wd & CMASK;
                  m_cnt[c]    = wd & CMASK;
                  m_pe[c]     = 0;
                  m_run[c]    = 1'b0;
                  m_to[c]     = old_to;
               end
               3: m_snap[c] = old_cnt;
               4: begin
                  m_pre[c] = wd & PMASK;
                  m_pe[c]  = 0;
               end
               default: ;
            endcase
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One cycle: predict, clock, compare readdata and irq against the model.
   task automatic cyc();
      logic [31:0] exp_rd;
      exp_rd = m_read(address);
      @(posedge clk);
      m_edge(chipselect && !write_n, address, writedata);
      #1;
      check("readdata", readdata, exp_rd);
      check("irq", {31'd0, irq}, {31'd0, |m_vec()});
   endtask

   task automatic idle(int n);
      chipselect = 1'b0;
      write_n    = 1'b1;
      repeat (n) cyc();
   endtask

   task automatic wr(int ch, int r, logic [31:0] d);
      address    = 5'((ch << 3) | r);
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      cyc();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(int ch, int r, output logic [31:0] v);
      address    = 5'((ch << 3) | r);
      chipselect = 1'b1;
      write_n    = 1'b1;
      cyc();
      v          = readdata;
      chipselect = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] v;
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = '0;
      writedata  = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset readdata", readdata, 32'd0);
      check("reset irq", {31'd0, irq}, 32'd0);
      reset_n = 1'b1;

      rd(0, 2, v); check("reset period", v, DEFP);
      rd(2, 0, v); check("reset status", v, 32'd0);

      // Continuous ch0: timeout every 5 cycles, clear races the event.
      wr(0, 2, 32'd4);
      wr(0, 4, 32'd0);
      wr(0, 1, 32'h3);
      wr(0, 1, 32'h7);
      for (int i = 1; i <= 5; i++) begin
         cyc();
         if (i < 5) check("ch0 irq early", {31'd0, irq}, 32'd0);
      end
      check("ch0 irq at 5", {31'd0, irq}, 32'd1);
      idle(4);
      wr(0, 0, 32'd0);
      check("clear vs timeout", {31'd0, irq}, 32'd1);
      idle(2);
      wr(0, 0, 32'd0);
      check("ch0 cleared", {31'd0, irq}, 32'd0);
      wr(0, 1, 32'hB);

      // One-shot ch1 with prescale: 12-cycle interval.
      wr(1, 2, 32'd2);
      wr(1, 4, 32'd3);
      wr(1, 1, 32'h4);
      idle(11);
      rd(1, 0, v); check("ch1 running", v, 32'h2);
      rd(1, 0, v); check("ch1 expired", v, 32'h1);
      wr(1, 3, 32'd0);
      rd(1, 3, v); check("ch1 hold", v, 32'd2);

      // PERIOD write stops a running channel.
      wr(2, 2, 32'd50);
      wr(2, 1, 32'h4);
      idle(7);
      wr(2, 2, 32'd100);
      rd(2, 0, v); check("ch2 stopped", v, 32'd0);
      wr(2, 3, 32'd0);
      rd(2, 3, v); check("ch2 snapshot", v, 32'd100);

      // Two interrupting channels.
      wr(0, 2, 32'd3);
      wr(0, 1, 32'h7);
      wr(3, 2, 32'd2);
      wr(3, 1, 32'h7);
      idle(20);
      wr(0, 1, 32'h9);
      rd(0, 5, v); check("irq_vec both", v, 32'h9);
      wr(0, 0, 32'd0);
      rd(0, 5, v); check("irq_vec ch3", v, 32'h8);
      check("irq ch3 only", {31'd0, irq}, 32'd1);

      // Asynchronous reset mid-count.
      wr(0, 1, 32'h7);
      idle(2);
      #2 reset_n = 1'b0;
      #1;
      check("async readdata", readdata, 32'd0);
      check("async irq", {31'd0, irq}, 32'd0);
      m_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
      rd(0, 0, v); check("post-rst status", v, 32'd0);
      rd(0, 2, v); check("post-rst period", v, DEFP);
      rd(3, 1, v); check("post-rst control", v, 32'd0);
      rd(0, 5, v); check("post-rst irq_vec", v, 32'd0);
      idle(3);
      rd(0, 0, v); check("post-rst no run", v, 32'd0);

      // Randomized register traffic.
      for (int i = 0; i < 600; i++) begin
         int ch = $urandom_range(0, NCH - 1);
         int r  = $urandom_range(0, 7);
         if ($urandom_range(0, 2) == 0) begin
            logic [31:0] d;
            case (r)
               2: d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 7);
               4: d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 2);
               default: d = $urandom;
            endcase
            wr(ch, r, d);
         end else if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            rd(ch, r, v);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/system_0_timer_multi.md
SYSTEM_0_TIMER_MULTI -- requirements
Module: system_0_timer_multi

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 32, counter and period width in bits (8..32).
REQ-003 SHALL have parameter PRESCALE_WIDTH, default 16, prescaler width in bits (1..16).
REQ-004 SHALL have parameter DEFAULT_PERIOD, default 49999, reset value of every channel's period and counter.
REQ-005 SHALL have port clk, input, 1 bit, the single clock.
REQ-006 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port address, input, clog2(NUM_CHANNELS)+3 bits: upper bits select the channel, low 3 bits select the register.
REQ-008 SHALL have ports chipselect, input, 1 bit, and write_n, input, 1 bit (Avalon slave, write = chipselect && !write_n).
REQ-009 SHALL have port writedata, input, 32 bits.
REQ-010 SHALL have port readdata, output, 32 bits, registered.
REQ-011 SHALL have port irq, output, 1 bit, OR of all channel interrupts.

Function
REQ-012 Per-channel register map SHALL be: 0 STATUS (b0 TO, b1 RUN; any write clears TO); 1 CONTROL (b0 ITO, b1 CONT, b2 START, b3 STOP; b2/b3 are strobes and read 0); 2 PERIOD; 3 SNAPSHOT; 4 PRESCALE; 5 IRQ_VEC (read-only, NUM_CHANNELS bits, TO&ITO of all channels); 6-7 read 0.
REQ-013 readdata SHALL present the addressed register one cycle after the address is sampled, regardless of chipselect; unused upper bits read 0.
REQ-014 Channel selects beyond NUM_CHANNELS-1 SHALL read 0 and ignore writes.
REQ-015 PERIOD, PRESCALE and CONTROL writes SHALL take writedata[COUNTER_WIDTH-1:0], [PRESCALE_WIDTH-1:0] and [3:0] respectively.
REQ-016 Prescaler SHALL count down from PRESCALE to 0 while RUN; a tick is issued in the cycle it equals 0, after which it reloads PRESCALE; PRESCALE=0 gives a tick every cycle.
REQ-017 On a tick with counter != 0 the counter SHALL decrement by 1.
REQ-018 On a tick with counter == 0 the counter SHALL reload PERIOD, TO SHALL set, and RUN SHALL clear if CONT=0; so the timeout interval is (PERIOD+1)*(PRESCALE+1) cycles.
REQ-019 A PERIOD write SHALL, in the following cycle, reload counter from the new PERIOD, reload the prescaler, and clear RUN.
REQ-020 A PRESCALE write SHALL reload the prescaler next cycle without affecting counter or RUN.
REQ-021 A CONTROL write with START=1 SHALL set RUN (START wins over simultaneous STOP); START while running SHALL not reload the counter.
REQ-022 A CONTROL write with STOP=1 and START=0 SHALL clear RUN; counter and prescaler hold.
REQ-023 A STATUS write coincident with a timeout in the same channel SHALL leave TO set (event wins over clear).
REQ-024 Any write to SNAPSHOT SHALL capture the current counter value into SNAPSHOT next cycle; reads return the captured value.
REQ-025 Channel irq SHALL be TO && ITO, combinational from registers; irq SHALL be the OR over channels.
REQ-026 A PERIOD write coincident with a channel tick SHALL take precedence (reload, stop, no TO set).

Reset
REQ-027 On reset_n low, asynchronously: counters and PERIOD = DEFAULT_PERIOD; PRESCALE = 0; SNAPSHOT = 0; CONTROL = 0; TO = 0; RUN = 0; readdata = 0; irq = 0.
REQ-028 Reset asserted mid-count SHALL abort all channels with no residual TO or RUN after release.

Verification
REQ-029 Ch0 PERIOD=4, PRESCALE=0, CONTROL=0x3 (ITO, CONT) then START -> TO/irq first sets 5 cycles after RUN, repeats every 5 cycles until STATUS write clears it.
REQ-030 Ch1 PERIOD=2, PRESCALE=3, CONT=0, START -> TO sets after 12 cycles, RUN reads 0, counter holds at 2.
REQ-031 Ch2 running, write PERIOD=100 -> RUN=0 next cycle, SNAPSHOT write then read returns 100.
REQ-032 Ch0 STATUS write in the exact cycle of a timeout -> TO remains 1, irq remains 1.
REQ-033 Ch0 and ch3 both timing out with ITO=1 -> IRQ_VEC reads 0x9; clearing ch0 -> 0x8, irq still 1.
REQ-034 Reset pulse while ch0 mid-count -> all registers return to REQ-027 values, readdata=0, irq=0.
